// File: rtl/wb_axis_bridge_if.sv
// rtl/wb_axis_bridge_if.sv - Wishbone slave and AXI-Stream bundle for wb_axis_bridge
interface wb_axis_bridge_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_dat_o;
    logic        wbs_ack_o;
    logic        ss_tvalid;
    logic [31:0] ss_tdata;
    logic        ss_tlast;
    logic        ss_tready;
    logic        sm_tvalid;
    logic [31:0] sm_tdata;
    logic        sm_tlast;
    logic        sm_tready;

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_dat_o, wbs_ack_o,
        output ss_tvalid, ss_tdata, ss_tlast,
        input  ss_tready,
        input  sm_tvalid, sm_tdata, sm_tlast,
        output sm_tready
    );

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_dat_o, wbs_ack_o,
        input  ss_tvalid, ss_tdata, ss_tlast,
        output ss_tready,
        output sm_tvalid, sm_tdata, sm_tlast,
        input  sm_tready
    );
endinterface

// File: rtl/wb_axis_bridge.sv
// rtl/wb_axis_bridge.sv - Wishbone register window bridging to FIR X/Y AXI-Stream FIFOs
module wb_axis_bridge #(
    parameter int          DEPTH = 4,
    parameter logic [23:0] BASE  = 24'h300000
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    wb_axis_bridge_if.slave bus
);
    localparam int            AW   = $clog2(DEPTH);
    localparam int            CW   = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    // Each FIFO entry is {tlast, data}
    logic [32:0]   in_mem  [DEPTH];
    logic [32:0]   out_mem [DEPTH];
    logic [AW-1:0] in_wr_q, in_rd_q, out_wr_q, out_rd_q;
    logic [CW-1:0] in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
    logic [31:0]   len_q, len_d, idx_q, idx_d, dat_q, dat_d;
    logic          ack_q, ack_d, seen_q, seen_d, rdy_q;

    logic          in_full, in_empty, out_full, out_empty;
    logic          req, push_x, pop_y, len_wr, ss_pop, sm_push, x_last;
    logic [31:0]   status;
    logic [32:0]   out_head;

    assign in_full   = (in_cnt_q == FULL);
    assign in_empty  = (in_cnt_q == '0);
    assign out_full  = (out_cnt_q == FULL);
    assign out_empty = (out_cnt_q == '0);

    // A request already being acked is complete; blocking it keeps ack to a single cycle
    assign req      = bus.wbs_cyc_i & bus.wbs_stb_i & (bus.wbs_adr_i[31:8] == BASE) & ~ack_q;
    assign ss_pop   = ~in_empty & bus.ss_tready;
    assign sm_push  = bus.sm_tvalid & bus.sm_tready;
    assign x_last   = (len_q != 32'd0) && (idx_q == len_q - 32'd1);
    assign out_head = out_mem[out_rd_q];
    assign status   = {16'h0, idx_q[7:0], 3'b000, seen_q, out_empty, out_full, in_empty, in_full};

    assign bus.ss_tvalid = ~in_empty;
    assign bus.ss_tdata  = in_mem[in_rd_q][31:0];
    assign bus.ss_tlast  = ~in_empty & in_mem[in_rd_q][32];
    // rdy_q holds tready low until the first clock after reset release
    assign bus.sm_tready = rdy_q & ~out_full;
    assign bus.wbs_ack_o = ack_q;
    assign bus.wbs_dat_o = dat_q;

    // Register decode, serviceability, and next-state of the bridge bookkeeping
    always_comb begin
        ack_d  = 1'b0;
        dat_d  = '0;
        push_x = 1'b0;
        pop_y  = 1'b0;
        len_wr = 1'b0;
        len_d  = len_q;
        idx_d  = idx_q;
        seen_d = seen_q;
        if (req) begin
            case (bus.wbs_adr_i[7:0])
                8'h10: begin
                    ack_d = 1'b1;
                    if (bus.wbs_we_i) len_wr = 1'b1;
                    else              dat_d  = len_q;
                end
                8'h80: begin
                    if (!bus.wbs_we_i) begin
                        ack_d = 1'b1;
                    end else if (!in_full) begin
                        ack_d  = 1'b1;
                        push_x = 1'b1;
                    end
                end
                8'h84: begin
                    if (bus.wbs_we_i) begin
                        ack_d = 1'b1;
                    end else if (!out_empty) begin
                        ack_d = 1'b1;
                        pop_y = 1'b1;
                        dat_d = out_head[31:0];
                    end
                end
                8'h88: begin
                    ack_d = 1'b1;
                    if (!bus.wbs_we_i) dat_d = status;
                end
                default: ack_d = 1'b1;
            endcase
        end
        if (len_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.wbs_sel_i[b]) len_d[8*b +: 8] = bus.wbs_dat_i[8*b +: 8];
            end
            idx_d  = '0;
            seen_d = 1'b0;
        end
        if (push_x) idx_d = x_last ? 32'd0 : idx_q + 32'd1;
        if (pop_y && out_head[32]) seen_d = 1'b1;
        in_cnt_d  = in_cnt_q + CW'(push_x) - CW'(ss_pop);
        out_cnt_d = out_cnt_q + CW'(sm_push) - CW'(pop_y);
    end

    // Control state; reset discards both FIFOs and any in-flight request
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            in_wr_q   <= '0;
            in_rd_q   <= '0;
            in_cnt_q  <= '0;
            out_wr_q  <= '0;
            out_rd_q  <= '0;
            out_cnt_q <= '0;
            len_q     <= '0;
            idx_q     <= '0;
            dat_q     <= '0;
            ack_q     <= 1'b0;
            seen_q    <= 1'b0;
            rdy_q     <= 1'b0;
        end else begin
            if (push_x)  in_wr_q  <= in_wr_q + 1'b1;
            if (ss_pop)  in_rd_q  <= in_rd_q + 1'b1;
            if (sm_push) out_wr_q <= out_wr_q + 1'b1;
            if (pop_y)   out_rd_q <= out_rd_q + 1'b1;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            dat_q     <= dat_d;
            ack_q     <= ack_d;
            seen_q    <= seen_d;
            rdy_q     <= 1'b1;
        end
    end

    // FIFO storage needs no reset; validity is tracked by the counts
    always_ff @(posedge wb_clk_i) begin
        if (push_x)  in_mem[in_wr_q]   <= {x_last, bus.wbs_dat_i};
        if (sm_push) out_mem[out_wr_q] <= {bus.sm_tlast, bus.sm_tdata};
    end
endmodule

// File: tb/tb_wb_axis_bridge.sv
// tb/tb_wb_axis_bridge.sv - randomized, model-checked bench for wb_axis_bridge
module tb_wb_axis_bridge;
    localparam int          DEPTH = 4;
    localparam logic [23:0] BASE  = 24'h300000;
    localparam logic [31:0] A_LEN = 32'h3000_0010;
    localparam logic [31:0] A_X   = 32'h3000_0080;
    localparam logic [31:0] A_Y   = 32'h3000_0084;
    localparam logic [31:0] A_ST  = 32'h3000_0088;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_axis_bridge_if bus();

    wb_axis_bridge #(.DEPTH(DEPTH), .BASE(BASE)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (bus)
    );

    logic [32:0] mq_in[$];
    logic [32:0] mq_out[$];
    logic [31:0] m_len, m_idx, m_dat;
    logic        m_seen, m_ack, m_rdy, m_sm_acc;

    logic        rand_ss = 1'b0;
    logic        rand_sm = 1'b0;
    int          checks = 0;
    int          errors = 0;
    string       lit_nm[64];
    logic [31:0] lit_got[64];
    logic [31:0] lit_exp[64];
    int          lit_wr = 0;
    int          lit_rd = 0;
    logic [31:0] acc_d[256];
    logic        acc_l[256];
    int          acc_n = 0;
    logic        ok;
    logic [31:0] rd;

    task automatic model_reset();
        mq_in.delete();
        mq_out.delete();
        m_len = '0; m_idx = '0; m_dat = '0;
        m_seen = 1'b0; m_ack = 1'b0; m_rdy = 1'b0; m_sm_acc = 1'b0;
    endtask

    // One clock edge of the bridge, from the register map and FIFO rules
    task automatic model_step();
        int          in_pre, out_pre;
        logic [32:0] w;
        logic        lastx, sm_ok, nack;
        logic [31:0] stat, ndat;
        m_sm_acc = 1'b0;
        if (rst) begin
            model_reset();
            return;
        end
        in_pre  = mq_in.size();
        out_pre = mq_out.size();
        sm_ok   = m_rdy && (out_pre < DEPTH) && bus.sm_tvalid;
        stat    = {16'h0, m_idx[7:0], 3'b000, m_seen, out_pre == 0, out_pre == DEPTH,
                   in_pre == 0, in_pre == DEPTH};
        if (in_pre > 0 && bus.ss_tready) void'(mq_in.pop_front());
        nack = 1'b0;
        ndat = '0;
        if (bus.wbs_cyc_i && bus.wbs_stb_i && bus.wbs_adr_i[31:8] == BASE && !m_ack) begin
            case (bus.wbs_adr_i[7:0])
                8'h10: begin
                    nack = 1'b1;
                    if (bus.wbs_we_i) begin
                        for (int b = 0; b < 4; b++)
                            if (bus.wbs_sel_i[b]) m_len[8*b +: 8] = bus.wbs_dat_i[8*b +: 8];
                        m_idx  = '0;
                        m_seen = 1'b0;
                    end else begin
                        ndat = m_len;
                    end
                end
                8'h80: begin
                    if (!bus.wbs_we_i) nack = 1'b1;
                    else if (in_pre < DEPTH) begin
                        nack  = 1'b1;
                        lastx = (m_len != 0) && (m_idx == m_len - 32'd1);
                        mq_in.push_back({lastx, bus.wbs_dat_i});
                        m_idx = lastx ? 32'd0 : m_idx + 32'd1;
                    end
                end
                8'h84: begin
                    if (bus.wbs_we_i) nack = 1'b1;
                    else if (out_pre > 0) begin
                        nack = 1'b1;
                        w    = mq_out.pop_front();
                        ndat = w[31:0];
                        if (w[32]) m_seen = 1'b1;
                    end
                end
                8'h88: begin
                    nack = 1'b1;
                    if (!bus.wbs_we_i) ndat = stat;
                end
                default: nack = 1'b1;
            endcase
        end
        if (sm_ok) begin
            mq_out.push_back({bus.sm_tlast, bus.sm_tdata});
            m_sm_acc = 1'b1;
        end
        m_ack = nack;
        m_dat = ndat;
        m_rdy = 1'b1;
    endtask

    task automatic lit(input string nm, input logic [31:0] got, input logic [31:0] exp);
        lit_nm[lit_wr % 64]  = nm;
        lit_got[lit_wr % 64] = got;
        lit_exp[lit_wr % 64] = exp;
        lit_wr++;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, got, exp);
        end
    endtask

    task automatic drive_bg();
        if (m_sm_acc) bus.sm_tvalid = 1'b0;
        if (rand_ss) bus.ss_tready = 1'($urandom_range(0, 1));
        if (rand_sm && !bus.sm_tvalid && $urandom_range(0, 1) == 1) begin
            bus.sm_tvalid = 1'b1;
            bus.sm_tdata  = $urandom;
            bus.sm_tlast  = ($urandom_range(0, 3) == 0);
        end
    endtask

    task automatic cyc();
        if (bus.ss_tvalid && bus.ss_tready) begin
            acc_d[acc_n % 256] = bus.ss_tdata;
            acc_l[acc_n % 256] = bus.ss_tlast;
            acc_n++;
        end
        @(posedge clk);
        model_step();
        @(negedge clk);
        #1;
        drive_bg();
    endtask

    task automatic wb_start(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel);
        bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = we;
        bus.wbs_adr_i = adr;  bus.wbs_dat_i = dat;  bus.wbs_sel_i = sel;
    endtask

    task automatic wb_stop();
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
    endtask

    task automatic wb_wait(input int budget, output logic got_ack, output logic [31:0] rdat);
        got_ack = 1'b0;
        rdat    = '0;
        for (int i = 0; i < budget && !got_ack; i++) begin
            cyc();
            if (bus.wbs_ack_o) begin
                got_ack = 1'b1;
                rdat    = bus.wbs_dat_o;
            end
        end
    endtask

    task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        output logic [31:0] rdat);
        logic a;
        wb_start(we, adr, dat, 4'hF);
        wb_wait(40, a, rdat);
        wb_stop();
        lit("wb_acked", {31'b0, a}, 32'd1);
    endtask

    task automatic sm_send(input logic [31:0] d, input logic l);
        bus.sm_tvalid = 1'b1;
        bus.sm_tdata  = d;
        bus.sm_tlast  = l;
        for (int i = 0; i < 20 && bus.sm_tvalid; i++) cyc();
        lit("sm_accepted", {31'b0, ~bus.sm_tvalid}, 32'd1);
    endtask

    // Compare process: literal expectations and per-cycle model comparison
    initial begin : compare
        forever begin
            @(negedge clk);
            while (lit_rd != lit_wr) begin
                chk(lit_nm[lit_rd % 64], lit_got[lit_rd % 64], lit_exp[lit_rd % 64]);
                lit_rd++;
            end
            chk("wbs_ack_o", {31'b0, bus.wbs_ack_o}, {31'b0, m_ack});
            chk("wbs_dat_o", bus.wbs_dat_o, m_dat);
            chk("ss_tvalid", {31'b0, bus.ss_tvalid}, {31'b0, mq_in.size() != 0});
            if (mq_in.size() != 0) begin
                chk("ss_tdata", bus.ss_tdata, mq_in[0][31:0]);
                chk("ss_tlast", {31'b0, bus.ss_tlast}, {31'b0, mq_in[0][32]});
            end
            chk("sm_tready", {31'b0, bus.sm_tready}, {31'b0, m_rdy && mq_out.size() < DEPTH});
        end
    end

    initial begin : main
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
        bus.wbs_sel_i = 4'h0; bus.wbs_adr_i = '0;   bus.wbs_dat_i = '0;
        bus.ss_tready = 1'b0; bus.sm_tvalid = 1'b0; bus.sm_tdata = '0; bus.sm_tlast = 1'b0;
        model_reset();
        #1;
        lit("rst_ack", {31'b0, bus.wbs_ack_o}, 32'd0);
        lit("rst_dat", bus.wbs_dat_o, 32'd0);
        lit("rst_ss_tvalid", {31'b0, bus.ss_tvalid}, 32'd0);
        lit("rst_ss_tlast", {31'b0, bus.ss_tlast}, 32'd0);
        lit("rst_sm_tready", {31'b0, bus.sm_tready}, 32'd0);
        cyc(); cyc();
        rst = 1'b0;
        cyc();
        lit("sm_tready_after_release", {31'b0, bus.sm_tready}, 32'd1);

        // length 3, three pushes streamed out with tlast on the third
        bus.ss_tready = 1'b1;
        acc_n = 0;
        xfer(1'b1, A_LEN, 32'd3, rd);
        xfer(1'b1, A_X, 32'd1, rd);
        xfer(1'b1, A_X, 32'd2, rd);
        xfer(1'b1, A_X, 32'd3, rd);
        repeat (3) cyc();
        lit("x_count", acc_n, 32'd3);
        lit("x0_data", acc_d[0], 32'd1);
        lit("x1_data", acc_d[1], 32'd2);
        lit("x2_data", acc_d[2], 32'd3);
        lit("x_lasts", {29'b0, acc_l[0], acc_l[1], acc_l[2]}, 32'b001);
        xfer(1'b0, A_ST, 32'd0, rd);
        lit("push_idx_after3", {24'b0, rd[15:8]}, 32'd0);

        // input FIFO fills at DEPTH; fifth push stalls until one word drains
        bus.ss_tready = 1'b0;
        for (int i = 0; i < 4; i++) xfer(1'b1, A_X, 32'hA0 + i, rd);
        xfer(1'b0, A_ST, 32'd0, rd);
        lit("in_full_bit", {31'b0, rd[0]}, 32'd1);
        wb_start(1'b1, A_X, 32'hA4, 4'hF);
        wb_wait(4, ok, rd);
        lit("fifth_push_stalls", {31'b0, ok}, 32'd0);
        bus.ss_tready = 1'b1;
        cyc();
        bus.ss_tready = 1'b0;
        wb_wait(10, ok, rd);
        wb_stop();
        lit("fifth_push_acked", {31'b0, ok}, 32'd1);
        bus.ss_tready = 1'b1;
        repeat (8) cyc();

        // Y pop waits for data; tlast word sets last_seen
        wb_start(1'b0, A_Y, 32'd0, 4'hF);
        wb_wait(6, ok, rd);
        lit("pop_empty_no_ack", {31'b0, ok}, 32'd0);
        bus.sm_tvalid = 1'b1; bus.sm_tdata = 32'hABCD; bus.sm_tlast = 1'b1;
        wb_wait(10, ok, rd);
        wb_stop();
        lit("pop_acked", {31'b0, ok}, 32'd1);
        lit("pop_data", rd, 32'hABCD);
        xfer(1'b0, A_ST, 32'd0, rd);
        lit("last_seen", {31'b0, rd[4]}, 32'd1);

        // output FIFO fills, back-pressures, and drains in order
        sm_send(32'h11, 1'b0);
        sm_send(32'h22, 1'b0);
        sm_send(32'h33, 1'b0);
        sm_send(32'h44, 1'b0);
        cyc();
        lit("sm_tready_full", {31'b0, bus.sm_tready}, 32'd0);
        xfer(1'b0, A_Y, 32'd0, rd);
        lit("y0", rd, 32'h11);
        lit("sm_tready_after_pop", {31'b0, bus.sm_tready}, 32'd1);
        xfer(1'b0, A_Y, 32'd0, rd);
        lit("y1", rd, 32'h22);
        xfer(1'b0, A_Y, 32'd0, rd);
        lit("y2", rd, 32'h33);
        xfer(1'b0, A_Y, 32'd0, rd);
        lit("y3", rd, 32'h44);

        // address outside BASE never acks; unmapped offset acks with 0
        wb_start(1'b0, 32'h3000_1000, 32'd0, 4'hF);
        wb_wait(16, ok, rd);
        wb_stop();
        lit("outside_base_no_ack", {31'b0, ok}, 32'd0);
        xfer(1'b1, 32'h3000_0020, 32'hDEAD, rd);
        xfer(1'b0, 32'h3000_0020, 32'd0, rd);
        lit("unmapped_read", rd, 32'd0);

        // reset mid-push with entries queued
        bus.ss_tready = 1'b0;
        xfer(1'b1, A_X, 32'h51, rd);
        xfer(1'b1, A_X, 32'h52, rd);
        sm_send(32'h99, 1'b1);
        lit("queued_tvalid", {31'b0, bus.ss_tvalid}, 32'd1);
        wb_start(1'b1, A_X, 32'h53, 4'hF);
        rst = 1'b1;
        model_reset();
        #1;
        lit("rst_mid_tvalid", {31'b0, bus.ss_tvalid}, 32'd0);
        lit("rst_mid_ack", {31'b0, bus.wbs_ack_o}, 32'd0);
        lit("rst_mid_sm_tready", {31'b0, bus.sm_tready}, 32'd0);
        wb_stop();
        cyc(); cyc();
        rst = 1'b0;
        cyc();
        xfer(1'b0, A_ST, 32'd0, rd);
        lit("status_after_rst", {27'b0, rd[4:0]}, 32'b01010);
        xfer(1'b0, A_LEN, 32'd0, rd);
        lit("len_after_rst", rd, 32'd0);

        // randomized traffic against the model
        rand_ss = 1'b1;
        rand_sm = 1'b1;
        for (int n = 0; n < 300; n++) begin
            logic [3:0]  sel;
            logic [31:0] d;
            case ($urandom_range(0, 9))
                0: begin
                    sel = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
                    d   = (sel == 4'hF) ? 32'($urandom_range(0, 4)) : $urandom;
                    wb_start(1'b1, A_LEN, d, sel);
                    wb_wait(40, ok, rd);
                    wb_stop();
                    lit("rand_len_acked", {31'b0, ok}, 32'd1);
                end
                1, 2, 3, 4: xfer(1'b1, A_X, $urandom, rd);
                5, 6, 7:    xfer(1'b0, A_Y, 32'd0, rd);
                8:          xfer(1'b0, A_ST, 32'd0, rd);
                default:    xfer(1'($urandom_range(0, 1)),
                                 {24'h300000, 6'($urandom_range(0, 63)), 2'b00}, $urandom, rd);
            endcase
            if ($urandom_range(0, 2) == 0) cyc();
        end
        rand_ss = 1'b0;
        rand_sm = 1'b0;
        repeat (3) cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_axis_bridge.md
WB_AXIS_BRIDGE -- requirements
Module: wb_axis_bridge

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the entry count of each stream FIFO (power of two, 2..16).
REQ-002 SHALL have parameter BASE, default 24'h300000, meaning the match value for wbs_adr_i[31:8].
REQ-003 SHALL have ports wb_clk_i in 1, the sole clock; all state updates on its rising edge.
REQ-004 SHALL have port wb_rst_i in 1, reset; asynchronous and active-high.
REQ-005 SHALL have ports wbs_cyc_i, wbs_stb_i, wbs_we_i in 1, and wbs_sel_i in 4, Wishbone classic slave controls.
REQ-006 SHALL have ports wbs_adr_i in 32, wbs_dat_i in 32, wbs_dat_o out 32, and wbs_ack_o out 1.
REQ-007 SHALL have ports ss_tvalid out 1, ss_tdata out 32, ss_tlast out 1 and ss_tready in 1, the AXI-Stream master feeding the FIR X[n] input.
REQ-008 SHALL have ports sm_tvalid in 1, sm_tdata in 32, sm_tlast in 1 and sm_tready out 1, the AXI-Stream slave taking the FIR Y[n] output.

Function
REQ-009 A request SHALL be when cyc & stb & (adr[31:8]==BASE); requests outside BASE SHALL never be acked.
REQ-010 The register map (adr[7:0]) SHALL be: 0x10 data_length RW; 0x80 X push WO; 0x84 Y pop RO; 0x88 status RO; every other offset reads 0, ignores writes, and acks.
REQ-011 wbs_ack_o SHALL be registered: a one-cycle pulse in the cycle after the request becomes serviceable, never high two consecutive cycles.
REQ-012 While wbs_ack_o is high, the request SHALL be treated as completed and not re-serviced.
REQ-013 Write strobes SHALL apply per byte to data_length; X push SHALL always take all 32 bits regardless of wbs_sel_i.
REQ-014 An X push SHALL be serviceable only when the input FIFO count < DEPTH, sampled in the request cycle; otherwise ack stalls.
REQ-015 A Y pop SHALL be serviceable only when the output FIFO is non-empty; wbs_dat_o SHALL equal the popped word in the ack cycle.
REQ-016 wbs_dat_o SHALL be 0 in every cycle without ack.
REQ-017 The input FIFO head SHALL drive ss_tdata; ss_tvalid = input FIFO non-empty; an entry pops when ss_tvalid & ss_tready.
REQ-018 Each pushed X SHALL carry a tlast bit: set when push index == data_length-1; the push index then returns to 0, otherwise it increments.
REQ-019 data_length==0 SHALL never set tlast.
REQ-020 A data_length write SHALL clear the push index.
REQ-021 sm_tready SHALL be !(output FIFO full); a word and its sm_tlast are stored when sm_tvalid & sm_tready.
REQ-022 Simultaneous push and pop on either FIFO SHALL both occur, with count unchanged.
REQ-023 Status SHALL be: bit0 in_full, bit1 in_empty, bit2 out_full, bit3 out_empty, bit4 last_seen, bits[15:8] push index, others 0.
REQ-024 last_seen SHALL set (sticky) when a Y word with tlast is popped over Wishbone, and clear on a data_length write.
REQ-025 ss_tvalid SHALL hold stable with ss_tdata until accepted, per AXI-Stream rules.

Reset
REQ-026 Asserting wb_rst_i SHALL immediately force wbs_ack_o=0, wbs_dat_o=0, ss_tvalid=0, ss_tlast=0, sm_tready=0, both FIFOs empty, push index 0, data_length 0, last_seen 0.
REQ-027 On the first clock after reset release, sm_tready SHALL be 1.
REQ-028 Reset mid-transaction SHALL abort it with no ack; FIFO contents SHALL be discarded.

Verification
REQ-029 Write 0x10=3; push X=1,2,3 with ss_tready=1 -> ss_tdata 1,2,3 in order, ss_tlast only on 3, push index 0 after.
REQ-030 ss_tready=0, DEPTH=4; push 5 words -> four acks, fifth stalls; raise ss_tready one cycle -> fifth acked; status bit0 reads 1 before.
REQ-031 Pop 0x84 with output FIFO empty -> no ack; drive sm_tvalid=1, sm_tdata=0xABCD, sm_tlast=1 -> ack with wbs_dat_o=0xABCD; status bit4=1.
REQ-032 Fill output FIFO (4 words, no pops) -> sm_tready=0; one pop -> sm_tready=1 next cycle; data order preserved.
REQ-033 Access 0x30001000 -> no ack for 16 cycles; access offset 0x20 -> ack, read 0.
REQ-034 Assert wb_rst_i mid-push with 2 entries queued -> ss_tvalid=0 immediately, status reads in_empty=1, out_empty=1 after release.
